// File: rtl/fetch_unit_if.sv
// Instruction-memory request/valid bus between the fetch unit and instruction memory.
interface fetch_unit_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_rdata;
  logic          imem_valid;

  modport master (output imem_req, imem_addr, input imem_rdata, imem_valid);
  modport slave  (input imem_req, imem_addr, output imem_rdata, imem_valid);
endinterface

// File: rtl/fetch_unit.sv
// SISC front end: PC/IR registers, instruction fetch over a req/valid bus,
// branch target load and IR field decode for the control unit.
module fetch_unit #(
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ir_load,
  input  logic             pc_write,
  input  logic             pc_sel,
  input  logic             br_sel,
  fetch_unit_if.master     imem,
  output logic [AW-1:0]    pc,
  output logic [DW-1:0]    ir,
  output logic [3:0]       opcode,
  output logic [3:0]       mm,
  output logic [15:0]      imm,
  output logic             fetch_busy,
  output logic             ir_valid,
  output logic             bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t        state, state_d;
  logic [AW-1:0] pc_d, addr_q, addr_d, imm_ext, target;
  logic [DW-1:0] ir_d;
  logic [7:0]    cnt, cnt_d;
  logic          req_q, req_d, busy_d, irv_d, err_d, branch;

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;

  assign opcode = ir[31:28];
  assign mm     = ir[27:24];
  assign imm    = ir[15:0];

  assign imm_ext = AW'($signed(imm));
  assign target  = br_sel ? imm_ext : pc + imm_ext;
  assign branch  = pc_write && pc_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    pc_d    = pc;
    ir_d    = ir;
    req_d   = req_q;
    addr_d  = addr_q;
    busy_d  = fetch_busy;
    irv_d   = 1'b0;
    err_d   = bus_err;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        // A branch load in the same cycle as ir_load wins; no fetch starts.
        if (branch) begin
          pc_d = target;
        end else if (ir_load) begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = pc;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      REQ: begin
        if (branch) err_d = 1'b1;
        // Valid is tested before the timeout so a reply on the last cycle succeeds.
        if (imem.imem_valid) begin
          ir_d    = imem.imem_rdata;
          pc_d    = pc + AW'(1);
          req_d   = 1'b0;
          busy_d  = 1'b0;
          irv_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt + 8'd1;
          if (cnt_d == 8'(TIMEOUT)) begin
            req_d   = 1'b0;
            busy_d  = 1'b0;
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        if (branch) pc_d = target;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= '0;
      ir         <= '0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      fetch_busy <= 1'b0;
      ir_valid   <= 1'b0;
      bus_err    <= 1'b0;
      cnt        <= '0;
    end else begin
      pc         <= pc_d;
      ir         <= ir_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      fetch_busy <= busy_d;
      ir_valid   <= irv_d;
      bus_err    <= err_d;
      cnt        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table-driven fetches and branches,
// scoreboarded IR results, and hand-written timeout / reset sequences.
module tb_fetch_unit;
  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ir_load = 1'b0, pc_write = 1'b0, pc_sel = 1'b0, br_sel = 1'b0;
  logic [15:0] pc;
  logic [31:0] ir;
  logic [3:0]  opcode, mm;
  logic [15:0] imm;
  logic        fetch_busy, ir_valid, bus_err;

  fetch_unit_if #(.AW(16), .DW(32)) bus ();

  fetch_unit #(.AW(16), .DW(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .ir_load(ir_load), .pc_write(pc_write),
    .pc_sel(pc_sel), .br_sel(br_sel), .imem(bus.master), .pc(pc), .ir(ir),
    .opcode(opcode), .mm(mm), .imm(imm), .fetch_busy(fetch_busy),
    .ir_valid(ir_valid), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] ir; logic [15:0] pc; } exp_t;
  typedef struct { logic [31:0] data; int delay; logic [3:0] op; logic [3:0] m; logic [15:0] im; } fvec_t;
  typedef struct { logic [15:0] setup; logic [15:0] im; logic br; logic psel; logic [15:0] exp; } bvec_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_pc = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every ir_valid pulse must match a queued fetch.
  always @(negedge clk) begin
    if (!rst && ir_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ir_valid: got ir %h expected no pulse", ir);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_ir", ir, mon_e.ir);
        chk("sb_opcode", {28'd0, opcode}, {28'd0, mon_e.ir[31:28]});
        chk("sb_mm", {28'd0, mm}, {28'd0, mon_e.ir[27:24]});
        chk("sb_imm", {16'd0, imm}, {16'd0, mon_e.ir[15:0]});
        chk("sb_pc", {16'd0, pc}, {16'd0, mon_e.pc});
      end
    end
  end

  // delay = REQ cycle in which imem_valid arrives (1..TMO); 0 = never.
  task automatic fetch(input logic [31:0] data, input int delay);
    logic [15:0] start_pc;
    start_pc = exp_pc;
    @(negedge clk); ir_load = 1'b1;
    @(negedge clk); ir_load = 1'b0;
    for (int k = 1; k <= TMO; k++) begin
      chk("req_held", {31'd0, bus.imem_req}, 32'd1);
      chk("addr_stable", {16'd0, bus.imem_addr}, {16'd0, start_pc});
      chk("busy_high", {31'd0, fetch_busy}, 32'd1);
      chk("pc_hold", {16'd0, pc}, {16'd0, start_pc});
      if (k == delay) begin
        bus.imem_valid = 1'b1;
        bus.imem_rdata = data;
        sb.push_back('{data, start_pc + 16'd1});
        exp_pc = start_pc + 16'd1;
      end
      @(negedge clk);
      bus.imem_valid = 1'b0;
      bus.imem_rdata = $urandom;
      if (k == delay) break;
    end
    if (delay == 0) begin
      chk("to_req_drop", {31'd0, bus.imem_req}, 32'd0);
      chk("to_bus_err", {31'd0, bus_err}, 32'd1);
      chk("to_busy", {31'd0, fetch_busy}, 32'd0);
      chk("to_pc", {16'd0, pc}, {16'd0, start_pc});
    end else begin
      chk("ir_valid_pulse", {31'd0, ir_valid}, 32'd1);
      chk("done_busy", {31'd0, fetch_busy}, 32'd0);
      chk("done_req", {31'd0, bus.imem_req}, 32'd0);
      @(negedge clk);
      chk("ir_valid_once", {31'd0, ir_valid}, 32'd0);
    end
  endtask

  task automatic branch(input logic psel, input logic br);
    @(negedge clk); pc_write = 1'b1; pc_sel = psel; br_sel = br;
    @(negedge clk); pc_write = 1'b0; pc_sel = 1'b0; br_sel = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; bus.imem_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    exp_pc = '0;
    sb.delete();
  endtask

  fvec_t fv[4];
  bvec_t bv[4];

  initial begin
    logic [15:0] start_pc;
    fv[0] = '{32'h8123_0004, 1,   4'h8, 4'h1, 16'h0004};
    fv[1] = '{32'h1234_5678, 5,   4'h1, 4'h2, 16'h5678};
    fv[2] = '{32'hA5F0_FFFE, 2,   4'hA, 4'h5, 16'hFFFE};
    fv[3] = '{32'hDEAD_BEEF, TMO, 4'hD, 4'hE, 16'hBEEF};
    bv[0] = '{16'h0010, 16'hFFFE, 1'b0, 1'b1, 16'h000E};
    bv[1] = '{16'h0010, 16'h0040, 1'b1, 1'b1, 16'h0040};
    bv[2] = '{16'hFFFF, 16'h0002, 1'b0, 1'b1, 16'h0001};
    bv[3] = '{16'h0123, 16'h0050, 1'b1, 1'b0, 16'h0123};
    bus.imem_valid = 1'b0;
    bus.imem_rdata = '0;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_pc", {16'd0, pc}, 32'd0);
    chk("rst_ir", ir, 32'd0);
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_addr", {16'd0, bus.imem_addr}, 32'd0);
    chk("rst_busy", {31'd0, fetch_busy}, 32'd0);
    chk("rst_irv", {31'd0, ir_valid}, 32'd0);
    chk("rst_err", {31'd0, bus_err}, 32'd0);

    for (int i = 0; i < 4; i++) begin
      fetch(fv[i].data, fv[i].delay);
      chk("fv_opcode", {28'd0, opcode}, {28'd0, fv[i].op});
      chk("fv_mm", {28'd0, mm}, {28'd0, fv[i].m});
      chk("fv_imm", {16'd0, imm}, {16'd0, fv[i].im});
      chk("fv_err", {31'd0, bus_err}, 32'd0);
    end
    chk("fv_pc_final", {16'd0, pc}, 32'd4);

    for (int i = 0; i < 4; i++) begin
      fetch({16'h0000, bv[i].setup - 16'd1}, 1);
      branch(1'b1, 1'b1);
      exp_pc = bv[i].setup - 16'd1;
      chk("bv_setup", {16'd0, pc}, {16'd0, exp_pc});
      fetch({16'h3000, bv[i].im}, 1);
      branch(bv[i].psel, bv[i].br);
      exp_pc = bv[i].exp;
      chk("bv_target", {16'd0, pc}, {16'd0, bv[i].exp});
    end

    // ir_load together with a branch in IDLE: branch only (imm = 0x0050).
    @(negedge clk); ir_load = 1'b1; pc_write = 1'b1; pc_sel = 1'b1; br_sel = 1'b1;
    @(negedge clk); ir_load = 1'b0; pc_write = 1'b0; pc_sel = 1'b0; br_sel = 1'b0;
    exp_pc = 16'h0050;
    chk("both_pc", {16'd0, pc}, 32'h0050);
    chk("both_no_req", {31'd0, bus.imem_req}, 32'd0);
    @(negedge clk);
    chk("both_no_req2", {31'd0, bus.imem_req}, 32'd0);

    // Branch and ir_load during REQ.
    start_pc = exp_pc;
    @(negedge clk); ir_load = 1'b1;
    @(negedge clk); ir_load = 1'b0; pc_write = 1'b1; pc_sel = 1'b1; br_sel = 1'b0;
    @(negedge clk); pc_write = 1'b0; pc_sel = 1'b0; ir_load = 1'b1;
    chk("req_br_pc", {16'd0, pc}, {16'd0, start_pc});
    chk("req_br_err", {31'd0, bus_err}, 32'd1);
    chk("req_br_req", {31'd0, bus.imem_req}, 32'd1);
    @(negedge clk); ir_load = 1'b0; bus.imem_valid = 1'b1; bus.imem_rdata = 32'hC0DE_1234;
    sb.push_back('{32'hC0DE_1234, start_pc + 16'd1});
    exp_pc = start_pc + 16'd1;
    @(negedge clk); bus.imem_valid = 1'b0;
    @(negedge clk);
    chk("no_second_req", {31'd0, bus.imem_req}, 32'd0);
    @(negedge clk);
    chk("no_second_req2", {31'd0, bus.imem_req}, 32'd0);
    chk("req_br_pc_after", {16'd0, pc}, {16'd0, exp_pc});

    // Timeout, then a prompt fetch with bus_err still sticky.
    do_reset();
    chk("rst2_err", {31'd0, bus_err}, 32'd0);
    fetch(32'hFFFF_FFFF, 0);
    chk("to_ir", ir, 32'd0);
    fetch(32'h2345_0001, 1);
    chk("sticky_err", {31'd0, bus_err}, 32'd1);
    chk("post_to_pc", {16'd0, pc}, 32'd1);

    // Asynchronous reset mid-REQ; a late valid must be ignored.
    @(negedge clk); ir_load = 1'b1;
    @(negedge clk); ir_load = 1'b0;
    @(negedge clk); rst = 1'b1;
    #1;
    chk("arst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("arst_addr", {16'd0, bus.imem_addr}, 32'd0);
    chk("arst_pc", {16'd0, pc}, 32'd0);
    chk("arst_ir", ir, 32'd0);
    chk("arst_busy", {31'd0, fetch_busy}, 32'd0);
    chk("arst_err", {31'd0, bus_err}, 32'd0);
    @(negedge clk); rst = 1'b0; bus.imem_valid = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk); bus.imem_valid = 1'b0;
    chk("late_valid_ir", ir, 32'd0);
    chk("late_valid_pc", {16'd0, pc}, 32'd0);
    @(negedge clk);
    chk("late_valid_irv", {31'd0, ir_valid}, 32'd0);

    chk("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Front end of the SISC datapath; sits directly upstream of the control FSM. Holds the PC and IR, fetches each instruction word from instruction memory over a request/valid handshake, and computes branch targets. Decodes the IR fields into opcode, mm and imm for the control unit. Tells the control unit when the fetched word is ready.

Parameters:
AW, 16, PC / instruction-memory address width
DW, 32, instruction word width
TIMEOUT, 15, max cycles to wait for imem_valid before aborting (1..255)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
ir_load  in  1  one-cycle pulse from ctrl: start fetch at current PC
pc_write  in  1  one-cycle pulse from ctrl: load PC with branch target (valid only with pc_sel=1)
pc_sel  in  1  1 = branch write; 0 = no action on pc_write
br_sel  in  1  1 = absolute target (imm); 0 = relative target (PC + imm)
imem_req  out  1  request to instruction memory
imem_addr  out  AW  fetch address
imem_rdata  in  DW  instruction word, sampled when imem_valid=1
imem_valid  in  1  memory data valid, one cycle
pc  out  AW  current PC
ir  out  DW  instruction register
opcode  out  4  ir[31:28]
mm  out  4  ir[27:24]
imm  out  16  ir[15:0]
fetch_busy  out  1  1 while a fetch is in flight
ir_valid  out  1  one-cycle pulse when IR has been updated
bus_err  out  1  sticky: timeout or illegal branch write

Behaviour:
- Reset (async, rst=1): pc=0, ir=0, imem_req=0, imem_addr=0, fetch_busy=0, ir_valid=0, bus_err=0, state=IDLE, timeout counter=0. Reset mid-fetch abandons the fetch; a late imem_valid after release is ignored (IDLE ignores imem_valid).
- States: IDLE, REQ, DONE.
- IDLE: ir_load=1 -> REQ; imem_req=1, imem_addr=pc, fetch_busy=1, counter cleared, all registered on that edge.
- REQ: imem_req and imem_addr held stable. On imem_valid=1: ir<=imem_rdata, pc<=pc+1 (mod 2^AW), imem_req<=0 -> DONE. Otherwise counter increments; when counter reaches TIMEOUT with no valid: imem_req<=0, bus_err<=1, ir and pc unchanged -> IDLE.
- DONE: ir_valid=1 for exactly this cycle, fetch_busy=0 -> IDLE. Minimum fetch latency: ir_load edge to ir_valid = 2 cycles when imem_valid arrives in the first REQ cycle.
- imem_valid in the same cycle as the TIMEOUT expiry counts as success (valid wins).
- Branch: in IDLE or DONE, pc_write=1 with pc_sel=1 loads pc with the target on that edge. br_sel=1: target=imm. br_sel=0: target=pc+imm, 16-bit two's-complement add; carry is discarded, so the result wraps. pc_write with pc_sel=0 is a no-op.
- pc_write=1 with pc_sel=1 while in REQ: PC unchanged, bus_err<=1.
- ir_load while in REQ or DONE: ignored, no queueing.
- ir_load and pc_write in the same IDLE cycle: the branch load takes priority. No fetch is started, because ctrl issues them in different states.
- opcode, mm and imm are combinational slices of the registered ir.
- bus_err clears only on rst.

Test Plan:
- Reset then ir_load, imem_valid in the first REQ cycle with rdata=32'h8123_0004 -> imem_addr=0, ir=32'h81230004, opcode=8, mm=1, imm=0004, pc=1, ir_valid pulses 2 cycles after ir_load.
- Memory delay of 5 cycles -> imem_req held 5 cycles with imem_addr stable, fetch_busy=1 throughout, pc increments only at valid, bus_err=0.
- pc=16'h0010, pc_write=1, pc_sel=1: br_sel=0 with imm=16'hFFFE -> pc=16'h000E; br_sel=1 with imm=16'h0040 -> pc=16'h0040; pc=16'hFFFF with relative imm=2 -> pc=16'h0001 (wrap).
- No imem_valid for TIMEOUT=15 cycles -> imem_req drops, bus_err=1, ir and pc unchanged. A following fetch with a prompt valid succeeds with bus_err still 1.
- pc_write/pc_sel=1 during REQ -> pc unchanged, bus_err=1. ir_load during REQ -> no second request issued.
- rst asserted mid-REQ -> all outputs return to reset values asynchronously. imem_valid=1 arriving after rst release leaves ir=0.
